rv_bus_arb: RTL and testbench

RV_BUS_ARB -- requirements
Module: rv_bus_arb

---
 rtl/rv_bus_arb.sv | 175 +++++++++++++++++
 tb/tb_rv_bus_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bus_arb.sv
// rv_bus_arb -- two-requester Wishbone master arbiter.
//
// Shares a single classic Wishbone master port between an instruction
// fetch port and a load/store (data) port. Data requests win by default,
// but only for DATA_BURST_MAX consecutive grants while a fetch is waiting,
// so the fetch side cannot be starved. A transfer that gets no i_wb_ack
// within TIMEOUT_CYCLES cycles is aborted and reported through an err pulse.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_if_req, i_if_adr      fetch request, word address [31:2]
//   o_if_ack, o_if_err      fetch completion / timeout pulses
//   o_if_dat                fetch read data (valid with o_if_ack)
//   i_ls_req, i_ls_we       data request, write enable
//   i_ls_adr, i_ls_dat      data byte address, write data
//   i_ls_sel                data byte lane select
//   o_ls_ack, o_ls_err      data completion / timeout pulses
//   o_ls_dat                data read data (valid with o_ls_ack)
//   o_wb_*                  registered Wishbone master outputs
//   i_wb_dat, i_wb_ack      Wishbone slave response
module rv_bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DATA_BURST_MAX = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [29:0] i_if_adr,
  output logic        o_if_ack,
  output logic        o_if_err,
  output logic [31:0] o_if_dat,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_dat,
  input  logic [3:0]  i_ls_sel,
  output logic        o_ls_ack,
  output logic        o_ls_err,
  output logic [31:0] o_ls_dat,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] BURST_MAX = 2'(DATA_BURST_MAX);

  state_t      state_q, state_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        if_err_q, if_err_d;
  logic        ls_err_q, ls_err_d;

  logic busy;
  logic decide;
  logic timeout;
  logic want_data;
  logic grant_data;
  logic grant_fetch;

  // Arbitration happens whenever the bus is free or is about to become
  // free this cycle (ack cycle), which gives back-to-back transfers.
  assign busy        = (state_q != IDLE);
  assign decide      = !busy || i_wb_ack;
  assign timeout     = busy && !i_wb_ack && (tmo_q == TMO_LAST);
  assign want_data   = i_ls_req && (!i_if_req || (burst_q < BURST_MAX));
  assign grant_data  = decide && want_data;
  assign grant_fetch = decide && !want_data && i_if_req;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    tmo_d    = tmo_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    wb_sel_d = wb_sel_q;
    wb_we_d  = wb_we_q;
    if_err_d = 1'b0;
    ls_err_d = 1'b0;

    if (grant_data) begin
      state_d  = DATA;
      wb_adr_d = i_ls_adr;
      wb_dat_d = i_ls_dat;
      wb_sel_d = i_ls_sel;
      wb_we_d  = i_ls_we;
    end else if (grant_fetch) begin
      state_d  = FETCH;
      wb_adr_d = {i_if_adr, 2'b00};
      wb_sel_d = 4'hF;
      wb_we_d  = 1'b0;
    end else if (decide) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d  = IDLE;
      if_err_d = (state_q == FETCH);
      ls_err_d = (state_q == DATA);
    end

    // Counts only while a transfer is outstanding; any grant or return to
    // IDLE restarts it.
    if (grant_data || grant_fetch || (state_d == IDLE)) begin
      tmo_d = 8'd0;
    end else begin
      tmo_d = tmo_q + 8'd1;
    end

    // The burst limit only matters while a fetch is waiting.
    if (!i_if_req || grant_fetch) begin
      burst_d = 2'd0;
    end else if (grant_data && (burst_q < BURST_MAX)) begin
      burst_d = burst_q + 2'd1;
    end

    wb_cyc_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      burst_q  <= 2'd0;
      tmo_q    <= 8'd0;
      wb_adr_q <= 32'd0;
      wb_dat_q <= 32'd0;
      wb_sel_q <= 4'd0;
      wb_we_q  <= 1'b0;
      wb_cyc_q <= 1'b0;
      if_err_q <= 1'b0;
      ls_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      tmo_q    <= tmo_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_sel_q <= wb_sel_d;
      wb_we_q  <= wb_we_d;
      wb_cyc_q <= wb_cyc_d;
      if_err_q <= if_err_d;
      ls_err_q <= ls_err_d;
    end
  end

  // Acks are steered by the current grant; an ack in IDLE goes nowhere.
  assign o_if_ack = i_wb_ack && (state_q == FETCH);
  assign o_ls_ack = i_wb_ack && (state_q == DATA);
  assign o_if_dat = i_wb_dat;
  assign o_ls_dat = i_wb_dat;
  assign o_if_err = if_err_q;
  assign o_ls_err = ls_err_q;

  assign o_wb_adr = wb_adr_q;
  assign o_wb_dat = wb_dat_q;
  assign o_wb_sel = wb_sel_q;
  assign o_wb_we  = wb_we_q;
  assign o_wb_cyc = wb_cyc_q;
  assign o_wb_stb = wb_cyc_q;

endmodule

// File: tb/tb_rv_bus_arb.sv
// Testbench for rv_bus_arb: a table of per-cycle vectors (inputs applied for
// one cycle, outputs expected during that cycle) followed by hand-written
// sequences for timeout and reset-abort behaviour.
module tb_rv_bus_arb;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_if_req;
  logic [29:0] i_if_adr;
  logic        o_if_ack, o_if_err;
  logic [31:0] o_if_dat;
  logic        i_ls_req, i_ls_we;
  logic [31:0] i_ls_adr, i_ls_dat;
  logic [3:0]  i_ls_sel;
  logic        o_ls_ack, o_ls_err;
  logic [31:0] o_ls_dat;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_stb, o_wb_cyc;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  rv_bus_arb #(
    .TIMEOUT_CYCLES(4),
    .DATA_BURST_MAX(2)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_if_req(i_if_req), .i_if_adr(i_if_adr),
    .o_if_ack(o_if_ack), .o_if_err(o_if_err), .o_if_dat(o_if_dat),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_adr(i_ls_adr),
    .i_ls_dat(i_ls_dat), .i_ls_sel(i_ls_sel),
    .o_ls_ack(o_ls_ack), .o_ls_err(o_ls_err), .o_ls_dat(o_ls_dat),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  typedef struct {
    logic        if_req;
    logic [29:0] if_adr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_adr;
    logic [31:0] ls_dat;
    logic [3:0]  ls_sel;
    logic        wb_ack;
    logic [31:0] wb_dat;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic        e_we;
    logic        e_if_ack;
    logic        e_ls_ack;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic ir, input logic [29:0] ia,
    input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
    input logic [3:0] ls, input logic ack, input logic [31:0] wd,
    input logic ec, input logic [31:0] ea, input logic [31:0] ed,
    input logic [3:0] es, input logic ew, input logic eia, input logic ela);
    vec_t r;
    r.if_req = ir; r.if_adr = ia; r.ls_req = lr; r.ls_we = lw;
    r.ls_adr = la; r.ls_dat = ld; r.ls_sel = ls; r.wb_ack = ack; r.wb_dat = wd;
    r.e_cyc = ec; r.e_adr = ea; r.e_dat = ed; r.e_sel = es; r.e_we = ew;
    r.e_if_ack = eia; r.e_ls_ack = ela;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_if_req = 1'b0; i_if_adr = '0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_adr = '0; i_ls_dat = '0; i_ls_sel = '0;
    i_wb_ack = 1'b0; i_wb_dat = '0;
  endtask

  initial begin
    int cyc_cnt;

    // Fetch only: word address 0x40 -> byte address 0x100
    vecs[0]  = mk(1, 30'h40, 0,0,32'h0,32'h0,4'h0, 0,32'h0,        0,32'h0,  32'h0,4'h0,0, 0,0);
    vecs[1]  = mk(1, 30'h40, 0,0,32'h0,32'h0,4'h0, 0,32'h0,        1,32'h100,32'h0,4'hF,0, 0,0);
    vecs[2]  = mk(1, 30'h40, 0,0,32'h0,32'h0,4'h0, 0,32'h0,        1,32'h100,32'h0,4'hF,0, 0,0);
    vecs[3]  = mk(0, 30'h40, 0,0,32'h0,32'h0,4'h0, 1,32'h13,       1,32'h100,32'h0,4'hF,0, 1,0);
    // Stray ack in IDLE goes nowhere
    vecs[4]  = mk(0, 30'h0,  0,0,32'h0,32'h0,4'h0, 1,32'h77,       0,32'h100,32'h0,4'hF,0, 0,0);
    vecs[5]  = mk(0, 30'h0,  0,0,32'h0,32'h0,4'h0, 0,32'h0,        0,32'h100,32'h0,4'hF,0, 0,0);
    // Simultaneous: store wins, fetch follows in the ack cycle
    vecs[6]  = mk(1, 30'h80, 1,1,32'h2000,32'hDEADBEEF,4'h3, 0,32'h0,         0,32'h100,32'h0,4'hF,0, 0,0);
    vecs[7]  = mk(1, 30'h80, 1,1,32'h2000,32'hDEADBEEF,4'h3, 0,32'h0,         1,32'h2000,32'hDEADBEEF,4'h3,1, 0,0);
    vecs[8]  = mk(1, 30'h80, 0,1,32'h2000,32'hDEADBEEF,4'h3, 1,32'hCAFEF00D,  1,32'h2000,32'hDEADBEEF,4'h3,1, 0,1);
    vecs[9]  = mk(0, 30'h80, 0,0,32'h0,32'h0,4'h0,           1,32'h12345678,  1,32'h200,32'hDEADBEEF,4'hF,0, 1,0);
    vecs[10] = mk(0, 30'h0,  0,0,32'h0,32'h0,4'h0,           0,32'h0,         0,32'h200,32'hDEADBEEF,4'hF,0, 0,0);
    // Starvation guard: D, D, F, D, D, F
    vecs[11] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 0,32'h0,  0,32'h200,32'hDEADBEEF,4'hF,0, 0,0);
    vecs[12] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 1,32'h11, 1,32'h3000,32'hA5A5A5A5,4'hC,1, 0,1);
    vecs[13] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 1,32'h22, 1,32'h3000,32'hA5A5A5A5,4'hC,1, 0,1);
    vecs[14] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 1,32'h33, 1,32'h400,32'hA5A5A5A5,4'hF,0, 1,0);
    vecs[15] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 1,32'h44, 1,32'h3000,32'hA5A5A5A5,4'hC,1, 0,1);
    vecs[16] = mk(1, 30'h100, 1,1,32'h3000,32'hA5A5A5A5,4'hC, 1,32'h55, 1,32'h3000,32'hA5A5A5A5,4'hC,1, 0,1);
    vecs[17] = mk(0, 30'h0,   0,0,32'h0,32'h0,4'h0,           1,32'h66, 1,32'h400,32'hA5A5A5A5,4'hF,0, 1,0);
    vecs[18] = mk(0, 30'h0,   0,0,32'h0,32'h0,4'h0,           0,32'h0,  0,32'h400,32'hA5A5A5A5,4'hF,0, 0,0);

    // Reset with requests and an ack present: everything must stay quiet
    idle_inputs();
    i_reset_n = 1'b0;
    i_if_req = 1'b1; i_ls_req = 1'b1; i_wb_ack = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("rst stb", {31'd0, o_wb_stb}, 32'd0);
    chk("rst adr", o_wb_adr, 32'd0);
    chk("rst dat", o_wb_dat, 32'd0);
    chk("rst sel", {28'd0, o_wb_sel}, 32'd0);
    chk("rst we", {31'd0, o_wb_we}, 32'd0);
    chk("rst acks", {30'd0, o_if_ack, o_ls_ack}, 32'd0);
    chk("rst errs", {30'd0, o_if_err, o_ls_err}, 32'd0);
    $display("reset: cyc=%b adr=%h acks=%b%b", o_wb_cyc, o_wb_adr, o_if_ack, o_ls_ack);
    idle_inputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge i_clk);
      i_if_req = vecs[k].if_req; i_if_adr = vecs[k].if_adr;
      i_ls_req = vecs[k].ls_req; i_ls_we  = vecs[k].ls_we;
      i_ls_adr = vecs[k].ls_adr; i_ls_dat = vecs[k].ls_dat; i_ls_sel = vecs[k].ls_sel;
      i_wb_ack = vecs[k].wb_ack; i_wb_dat = vecs[k].wb_dat;
      #1;
      chk($sformatf("v%0d cyc", k), {31'd0, o_wb_cyc}, {31'd0, vecs[k].e_cyc});
      chk($sformatf("v%0d stb", k), {31'd0, o_wb_stb}, {31'd0, vecs[k].e_cyc});
      chk($sformatf("v%0d adr", k), o_wb_adr, vecs[k].e_adr);
      chk($sformatf("v%0d dat", k), o_wb_dat, vecs[k].e_dat);
      chk($sformatf("v%0d sel", k), {28'd0, o_wb_sel}, {28'd0, vecs[k].e_sel});
      chk($sformatf("v%0d we", k), {31'd0, o_wb_we}, {31'd0, vecs[k].e_we});
      chk($sformatf("v%0d if_ack", k), {31'd0, o_if_ack}, {31'd0, vecs[k].e_if_ack});
      chk($sformatf("v%0d ls_ack", k), {31'd0, o_ls_ack}, {31'd0, vecs[k].e_ls_ack});
      chk($sformatf("v%0d errs", k), {30'd0, o_if_err, o_ls_err}, 32'd0);
      if (vecs[k].e_if_ack) chk($sformatf("v%0d if_dat", k), o_if_dat, vecs[k].wb_dat);
      if (vecs[k].e_ls_ack) chk($sformatf("v%0d ls_dat", k), o_ls_dat, vecs[k].wb_dat);
      $display("vec %0d: cyc=%b adr=%h we=%b sel=%h if_ack=%b ls_ack=%b",
               k, o_wb_cyc, o_wb_adr, o_wb_we, o_wb_sel, o_if_ack, o_ls_ack);
    end

    // Timeout: data transfer never acked, fetch waiting behind it
    @(negedge i_clk);
    idle_inputs();
    i_ls_req = 1'b1; i_ls_adr = 32'h4000; i_ls_sel = 4'hF;
    i_if_req = 1'b1; i_if_adr = 30'h200;
    @(posedge i_clk);
    cyc_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      #1;
      if (!o_wb_cyc) break;
      cyc_cnt++;
    end
    chk("tmo cyc cycles", cyc_cnt, 32'd4);
    chk("tmo ls_err", {31'd0, o_ls_err}, 32'd1);
    chk("tmo if_err", {31'd0, o_if_err}, 32'd0);
    chk("tmo ls_ack", {31'd0, o_ls_ack}, 32'd0);
    $display("timeout: cyc high %0d cycles, ls_err=%b", cyc_cnt, o_ls_err);
    i_ls_req = 1'b0;
    @(negedge i_clk);
    #1;
    chk("tmo err pulse width", {31'd0, o_ls_err}, 32'd0);
    chk("tmo fetch cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("tmo fetch adr", o_wb_adr, 32'h800);
    chk("tmo fetch we", {31'd0, o_wb_we}, 32'd0);
    i_wb_ack = 1'b1; i_wb_dat = 32'hBEEF0001; i_if_req = 1'b0;
    #1;
    chk("tmo fetch ack", {31'd0, o_if_ack}, 32'd1);
    chk("tmo fetch dat", o_if_dat, 32'hBEEF0001);
    $display("timeout recovery: fetch adr=%h if_ack=%b", o_wb_adr, o_if_ack);
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    #1;
    chk("tmo done cyc", {31'd0, o_wb_cyc}, 32'd0);

    // Reset in the middle of a data transfer
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_adr = 32'h5000; i_ls_dat = 32'h55; i_ls_sel = 4'h1;
    @(negedge i_clk);
    #1;
    chk("rstmid busy cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("rstmid busy adr", o_wb_adr, 32'h5000);
    #1;
    i_reset_n = 1'b0;
    #1;
    i_wb_ack = 1'b1;
    #1;
    chk("rstmid cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("rstmid stb", {31'd0, o_wb_stb}, 32'd0);
    chk("rstmid acks", {30'd0, o_if_ack, o_ls_ack}, 32'd0);
    chk("rstmid errs", {30'd0, o_if_err, o_ls_err}, 32'd0);
    chk("rstmid adr", o_wb_adr, 32'd0);
    $display("reset mid-transfer: cyc=%b acks=%b%b", o_wb_cyc, o_if_ack, o_ls_ack);
    idle_inputs();
    i_if_req = 1'b1; i_if_adr = 30'h10;
    @(negedge i_clk);
    #1;
    chk("rstmid held cyc", {31'd0, o_wb_cyc}, 32'd0);
    i_reset_n = 1'b1;
    #1;
    chk("rstmid release cyc", {31'd0, o_wb_cyc}, 32'd0);
    @(negedge i_clk);
    #1;
    chk("rstmid fetch cyc", {31'd0, o_wb_cyc}, 32'd1);
    chk("rstmid fetch adr", o_wb_adr, 32'h40);
    chk("rstmid fetch sel", {28'd0, o_wb_sel}, 32'hF);
    chk("rstmid fetch errs", {30'd0, o_if_err, o_ls_err}, 32'd0);
    i_wb_ack = 1'b1; i_if_req = 1'b0;
    #1;
    chk("rstmid fetch ack", {31'd0, o_if_ack}, 32'd1);
    $display("after reset: fetch adr=%h if_ack=%b", o_wb_adr, o_if_ack);
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    #1;
    chk("final idle cyc", {31'd0, o_wb_cyc}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
